// File: rtl/noise_frame_scheduler.sv
// -----------------------------------------------------------------------------
// noise_frame_scheduler
//
// Sequences one frame of noise estimation. A frame is 2^nb blocks; each block
// streams 2^SAMPLES_LOG2 samples into an external statistics engine. After the
// engine reports the block variance, the scheduler accumulates it and tracks the
// running minimum. When the last block is in, it publishes the mean block
// variance (noise_est) and the minimum block variance (min_var) with a
// one-cycle noise_valid pulse.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   start_of_frame   : frame start request (only honoured while idle)
//   blocks_log2      : log2 of blocks per frame, sampled at frame accept,
//                      clamped to MAX_BLOCKS_LOG2
//   pix_valid        : upstream sample present
//   pix_ready        : scheduler is streaming; sample taken on valid && ready
//   eng_start        : one-cycle pulse, engine begins a new block
//   eng_sample_en    : engine consumes the current sample
//   eng_done         : engine variance result valid (used only while waiting)
//   eng_variance     : engine block variance
//   noise_valid      : one-cycle pulse, noise_est/min_var just updated
//   noise_est        : mean of the frame's block variances (truncating)
//   min_var          : minimum block variance of the frame
//   busy             : high whenever the scheduler is not idle
//   overrun_err      : one-cycle pulse after a start_of_frame that was ignored
// -----------------------------------------------------------------------------
module noise_frame_scheduler #(
    parameter int DATA_WIDTH      = 8,
    parameter int SAMPLES_LOG2    = 6,
    parameter int VAR_WIDTH       = 16,
    parameter int MAX_BLOCKS_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_of_frame,
    input  logic [3:0]           blocks_log2,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 eng_start,
    output logic                 eng_sample_en,
    input  logic                 eng_done,
    input  logic [VAR_WIDTH-1:0] eng_variance,
    output logic                 noise_valid,
    output logic [VAR_WIDTH-1:0] noise_est,
    output logic [VAR_WIDTH-1:0] min_var,
    output logic                 busy,
    output logic                 overrun_err
);

    // DATA_WIDTH only documents the upstream pixel format; no pixel data
    // passes through this block, so it contributes nothing to any width.
    localparam int ACC_W = VAR_WIDTH + MAX_BLOCKS_LOG2 + 0 * DATA_WIDTH;
    localparam int NB_W  = $clog2(MAX_BLOCKS_LOG2 + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_ENG,
        S_DONE
    } state_e;

    state_e                     state_q,      state_d;
    logic [NB_W-1:0]            nb_q,         nb_d;
    logic [SAMPLES_LOG2-1:0]    sample_cnt_q, sample_cnt_d;
    logic [MAX_BLOCKS_LOG2-1:0] blk_cnt_q,    blk_cnt_d;
    logic [ACC_W-1:0]           acc_q,        acc_d;
    logic [VAR_WIDTH-1:0]       min_q,        min_d;
    logic [VAR_WIDTH-1:0]       noise_est_q,  noise_est_d;
    logic [VAR_WIDTH-1:0]       min_var_q,    min_var_d;
    logic                       noise_valid_q, noise_valid_d;
    logic                       overrun_err_q, overrun_err_d;
    logic                       eng_start_raw;

    // Index of the final block of the frame: 2^nb - 1.
    logic [MAX_BLOCKS_LOG2-1:0] last_blk;
    assign last_blk = MAX_BLOCKS_LOG2'((32'd1 << nb_q) - 32'd1);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        nb_d          = nb_q;
        sample_cnt_d  = sample_cnt_q;
        blk_cnt_d     = blk_cnt_q;
        acc_d         = acc_q;
        min_d         = min_q;
        noise_est_d   = noise_est_q;
        min_var_d     = min_var_q;
        noise_valid_d = 1'b0;
        eng_start_raw = 1'b0;
        // Any request that arrives while a frame is in flight is dropped and
        // flagged; the frame itself carries on untouched.
        overrun_err_d = start_of_frame && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (start_of_frame) begin
                    nb_d          = (32'(blocks_log2) > MAX_BLOCKS_LOG2)
                                    ? NB_W'(MAX_BLOCKS_LOG2) : NB_W'(blocks_log2);
                    sample_cnt_d  = '0;
                    blk_cnt_d     = '0;
                    acc_d         = '0;
                    min_d         = '1;
                    eng_start_raw = 1'b1;
                    state_d       = S_STREAM;
                end
            end

            S_STREAM: begin
                // Only consumed samples advance the count, so gaps in
                // pix_valid stretch the block without changing its size.
                if (pix_valid) begin
                    if (&sample_cnt_q) begin
                        sample_cnt_d = '0;
                        state_d      = S_WAIT_ENG;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end

            S_WAIT_ENG: begin
                if (eng_done) begin
                    // The accumulator is wide enough for 2^MAX_BLOCKS_LOG2
                    // full-scale variances, so this sum cannot wrap.
                    acc_d     = acc_q + ACC_W'(eng_variance);
                    blk_cnt_d = blk_cnt_q + 1'b1;
                    if (eng_variance < min_q) begin
                        min_d = eng_variance;
                    end
                    if (blk_cnt_q == last_blk) begin
                        state_d = S_DONE;
                    end else begin
                        eng_start_raw = 1'b1;
                        state_d       = S_STREAM;
                    end
                end
            end

            S_DONE: begin
                // Block count is a power of two, so the mean is a shift.
                noise_est_d   = VAR_WIDTH'(acc_q >> nb_q);
                min_var_d     = min_q;
                noise_valid_d = 1'b1;
                state_d       = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            nb_q          <= '0;
            sample_cnt_q  <= '0;
            blk_cnt_q     <= '0;
            acc_q         <= '0;
            min_q         <= '1;
            noise_est_q   <= '0;
            min_var_q     <= '0;
            noise_valid_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            nb_q          <= nb_d;
            sample_cnt_q  <= sample_cnt_d;
            blk_cnt_q     <= blk_cnt_d;
            acc_q         <= acc_d;
            min_q         <= min_d;
            noise_est_q   <= noise_est_d;
            min_var_q     <= min_var_d;
            noise_valid_q <= noise_valid_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    // eng_start is decoded from inputs while idle; holding it low during reset
    // keeps a start_of_frame that overlaps reset from reaching the engine.
    assign eng_start     = eng_start_raw && rst_n;
    assign pix_ready     = (state_q == S_STREAM);
    assign eng_sample_en = (state_q == S_STREAM) && pix_valid;
    assign busy          = (state_q != S_IDLE);
    assign noise_valid   = noise_valid_q;
    assign noise_est     = noise_est_q;
    assign min_var       = min_var_q;
    assign overrun_err   = overrun_err_q;

endmodule
